// File: rtl/cmosnot_pkg.sv
// Shared definitions for the inverter bank and its built-in self-test.
// Holds the BIST state encoding and the per-step pattern parity.
package cmosnot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam logic PAT_EVEN = 1'b0;
    localparam logic PAT_ODD  = 1'b1;

    // Even steps drive all-zeros, odd steps all-ones.
    function automatic logic pattern_bit(input logic i_k_lsb);
        return i_k_lsb ? PAT_ODD : PAT_EVEN;
    endfunction

endpackage

// File: rtl/cmosnot_bist.sv
// Self-test sequencer: walks alternating patterns through the bank and
// counts steps whose registered output is not the inverse of the pattern.
module cmosnot_bist
    import cmosnot_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIST_STEPS = 4,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_f,
    output logic             o_sel,
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err
);

    localparam int KW = (BIST_STEPS > 1) ? $clog2(BIST_STEPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BIST_STEPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    bist_state_t r_state;
    bist_state_t w_state_nxt;

    logic [KW-1:0]    r_k;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_nxt;
    logic             r_pass;
    logic [WIDTH-1:0] w_pattern;
    logic             w_step_fail;
    logic             w_last;
    logic             w_launch;

    assign w_pattern   = {WIDTH{pattern_bit(r_k[0])}};
    assign w_step_fail = (i_f != ~w_pattern);
    assign w_last      = (r_k == K_LAST);
    assign w_launch    = (r_state == ST_IDLE) && i_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_DRIVE;
            ST_DRIVE: w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            ST_DRIVE: o_busy = 1'b1;
            ST_CHECK: o_busy = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default:  o_busy = 1'b0;
        endcase
    end

    // Saturating count so long runs never wrap back to a clean result.
    always_comb begin
        w_err_nxt = r_err;
        if ((r_state == ST_CHECK) && w_step_fail && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k    <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (w_launch) begin
            r_k    <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_err <= w_err_nxt;
            if (w_last) begin
                r_k    <= '0;
                r_pass <= (w_err_nxt == '0);
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign o_sel     = o_busy;
    assign o_pattern = w_pattern;
    assign o_pass    = r_pass;
    assign o_err     = r_err;

endmodule

// File: rtl/cmosnot_bank.sv
// Bank of registered inverters with selectable pass-through, fault
// injection and a built-in self-test that borrows the datapath register.
module cmosnot_bank
    import cmosnot_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIST_STEPS = 4,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             mode,
    input  logic [WIDTH-1:0] fault,
    input  logic             bist_start,
    output logic [WIDTH-1:0] f,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [ERR_W-1:0] err_count
);

    logic             w_sel;
    logic [WIDTH-1:0] w_pattern;
    logic [WIDTH-1:0] w_src;
    logic             w_inv;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] r_f;

    cmosnot_bist #(
        .WIDTH      (WIDTH),
        .BIST_STEPS (BIST_STEPS),
        .ERR_W      (ERR_W)
    ) u_bist (
        .clk       (clk),
        .rst       (rst),
        .i_start   (bist_start),
        .i_f       (r_f),
        .o_sel     (w_sel),
        .o_pattern (w_pattern),
        .o_busy    (bist_busy),
        .o_done    (bist_done),
        .o_pass    (bist_pass),
        .o_err     (err_count)
    );

    // Self-test always inverts so a healthy channel returns ~pattern.
    assign w_src = w_sel ? w_pattern : x;
    assign w_inv = w_sel ? 1'b1 : ~mode;
    assign w_d   = (w_src ^ {WIDTH{w_inv}}) ^ fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f <= '0;
        end else begin
            r_f <= w_d;
        end
    end

    assign f = r_f;

endmodule
